fmul_issue_arbiter: RTL and testbench

- Shares one pipelined half-precision significand/exponent multiplier between NUM_REQ requesters.
- Round-robin arbitration picks at most one request per cycle and registers its operands onto the multiplier inputs.
- A requester-ID tag travels through a shadow shift register matched to the multiplier latency, so each product returns one-hot to the requester that issued it.
- Sits between the requester-side datapaths and the multiplier instance.

---
 rtl/fmul_issue_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_fmul_issue_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined half-precision multiplier among NUM_REQ requesters.
// Optional grant/conflict statistics counters are enabled with `define FMUL_ARB_STATS_EN.
module fmul_issue_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int PIPE_LAT = 4,
   parameter int SIG_W    = 11,
   parameter int EXP_W    = 5,
   parameter int PROD_W   = 22
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [NUM_REQ-1:0]       req_valid_in,
   output logic [NUM_REQ-1:0]       req_ready_out,
   input  logic [NUM_REQ*SIG_W-1:0] req_gx_in,
   input  logic [NUM_REQ*SIG_W-1:0] req_gy_in,
   input  logic [NUM_REQ*EXP_W-1:0] req_ex_in,
   input  logic [NUM_REQ*EXP_W-1:0] req_ey_in,
   input  logic                     flush_in,
   output logic                     mul_issue_out,
   output logic [SIG_W-1:0]         mul_gx_out,
   output logic [SIG_W-1:0]         mul_gy_out,
   output logic [EXP_W-1:0]         mul_ex_out,
   output logic [EXP_W-1:0]         mul_ey_out,
   input  logic [PROD_W-1:0]        mul_product_in,
   output logic [NUM_REQ-1:0]       rsp_valid_out,
   output logic [PROD_W-1:0]        rsp_product_out,
   output logic                     busy_out
`ifdef FMUL_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]    stat_grant_cnt_out,
   output logic [15:0]              stat_conflict_cnt_out
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(PIPE_LAT + 3);
   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic              mul_issue_q, mul_issue_d;
   logic [ID_W-1:0]   issue_id_q, issue_id_d;
   logic [SIG_W-1:0]  mul_gx_q, mul_gx_d, mul_gy_q, mul_gy_d;
   logic [EXP_W-1:0]  mul_ex_q, mul_ex_d, mul_ey_q, mul_ey_d;
   logic [PIPE_LAT-1:0]           tag_vld_q, tag_vld_d;
   logic [PIPE_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [PROD_W-1:0]  rsp_product_q, rsp_product_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;

   logic              grant_found_s;
   logic              grant_s;
   logic [ID_W-1:0]   grant_id_s;
   logic [ID_W:0]     idx_s;

   // Round-robin search starting at ptr_q; flush and reset suppress any grant.
   always_comb begin
      grant_found_s = 1'b0;
      grant_id_s    = '0;
      idx_s         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s = {1'b0, ptr_q} + (ID_W+1)'(i);
         idx_s = (idx_s >= NUM_REQ_W) ? (idx_s - NUM_REQ_W) : idx_s;
         if (!grant_found_s && req_valid_in[idx_s[ID_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_id_s    = idx_s[ID_W-1:0];
         end else begin
            grant_id_s    = grant_id_s;
         end
      end
      grant_s = grant_found_s & ~flush_in & ~rst_in;
      if (grant_s) begin
         req_ready_out = ONE_HOT0 << grant_id_s;
      end else begin
         req_ready_out = '0;
      end
   end

   // Issue register, pointer advance, tag pipe, response and in-flight count.
   always_comb begin
      ptr_d         = ptr_q;
      mul_issue_d   = grant_s;
      issue_id_d    = issue_id_q;
      mul_gx_d      = mul_gx_q;
      mul_gy_d      = mul_gy_q;
      mul_ex_d      = mul_ex_q;
      mul_ey_d      = mul_ey_q;
      if (grant_s) begin
         ptr_d      = (grant_id_s == ID_W'(NUM_REQ-1)) ? '0 : grant_id_s + ID_W'(1);
         issue_id_d = grant_id_s;
         mul_gx_d   = req_gx_in[grant_id_s*SIG_W +: SIG_W];
         mul_gy_d   = req_gy_in[grant_id_s*SIG_W +: SIG_W];
         mul_ex_d   = req_ex_in[grant_id_s*EXP_W +: EXP_W];
         mul_ey_d   = req_ey_in[grant_id_s*EXP_W +: EXP_W];
      end else begin
         ptr_d      = ptr_q;
      end

      tag_vld_d    = '0;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = mul_issue_q & ~flush_in;
      tag_id_d[0]  = issue_id_q;
      for (int k = 1; k < PIPE_LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1] & ~flush_in;
         tag_id_d[k]  = tag_id_q[k-1];
      end

      rsp_valid_d   = '0;
      rsp_product_d = rsp_product_q;
      if (tag_vld_q[PIPE_LAT-1] && !flush_in) begin
         rsp_valid_d   = ONE_HOT0 << tag_id_q[PIPE_LAT-1];
         rsp_product_d = mul_product_in;
      end else begin
         rsp_valid_d   = '0;
      end

      // A grant and a response pulse in the same cycle cancel out.
      cnt_d = cnt_q;
      if (flush_in) begin
         cnt_d = '0;
      end else begin
         case ({grant_s, |rsp_valid_q})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
      busy_d = (cnt_d != '0);
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ptr_q         <= '0;
         mul_issue_q   <= 1'b0;
         issue_id_q    <= '0;
         mul_gx_q      <= '0;
         mul_gy_q      <= '0;
         mul_ex_q      <= '0;
         mul_ey_q      <= '0;
         tag_vld_q     <= '0;
         tag_id_q      <= '0;
         rsp_valid_q   <= '0;
         rsp_product_q <= '0;
         cnt_q         <= '0;
         busy_q        <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         mul_issue_q   <= mul_issue_d;
         issue_id_q    <= issue_id_d;
         mul_gx_q      <= mul_gx_d;
         mul_gy_q      <= mul_gy_d;
         mul_ex_q      <= mul_ex_d;
         mul_ey_q      <= mul_ey_d;
         tag_vld_q     <= tag_vld_d;
         tag_id_q      <= tag_id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_product_q <= rsp_product_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
      end
   end

   assign mul_issue_out   = mul_issue_q;
   assign mul_gx_out      = mul_gx_q;
   assign mul_gy_out      = mul_gy_q;
   assign mul_ex_out      = mul_ex_q;
   assign mul_ey_out      = mul_ey_q;
   assign rsp_valid_out   = rsp_valid_q;
   assign rsp_product_out = rsp_product_q;
   assign busy_out        = busy_q;

`ifdef FMUL_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;
   logic [15:0]              conflict_cnt_q, conflict_cnt_d;
   logic                     conflict_s;

   // Saturating counters; two or more valids means v & (v-1) is non-zero.
   always_comb begin
      conflict_s  = ((req_valid_in & (req_valid_in - NUM_REQ'(1))) != '0);
      grant_cnt_d = grant_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s && (grant_id_s == ID_W'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
            grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
         end else begin
            grant_cnt_d[i] = grant_cnt_q[i];
         end
      end
      if (conflict_s && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end else begin
         conflict_cnt_d = conflict_cnt_q;
      end
   end

   // Statistics registers clear on reset only.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         grant_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt_q    <= grant_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign stat_grant_cnt_out    = grant_cnt_q;
   assign stat_conflict_cnt_out = conflict_cnt_q;
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Scoreboard bench for fmul_issue_arbiter: directed stimulus pushes expected responses, a monitor checks them.
module tb_fmul_issue_arbiter;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = 4'b0;
   logic [3:0]   req_ready;
   logic [43:0]  req_gx = '0, req_gy = '0;
   logic [19:0]  req_ex = '0, req_ey = '0;
   logic         flush = 1'b0;
   logic         mul_issue;
   logic [10:0]  mul_gx, mul_gy;
   logic [4:0]   mul_ex, mul_ey;
   logic [21:0]  mul_product;
   logic [3:0]   rsp_valid;
   logic [21:0]  rsp_product;
   logic         busy;
`ifdef FMUL_ARB_STATS_EN
   logic [63:0]  stat_grant;
   logic [15:0]  stat_conflict;
`endif

   fmul_issue_arbiter dut (
      .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_out(req_ready),
      .req_gx_in(req_gx), .req_gy_in(req_gy), .req_ex_in(req_ex), .req_ey_in(req_ey),
      .flush_in(flush), .mul_issue_out(mul_issue), .mul_gx_out(mul_gx), .mul_gy_out(mul_gy),
      .mul_ex_out(mul_ex), .mul_ey_out(mul_ey), .mul_product_in(mul_product),
      .rsp_valid_out(rsp_valid), .rsp_product_out(rsp_product), .busy_out(busy)
`ifdef FMUL_ARB_STATS_EN
      , .stat_grant_cnt_out(stat_grant), .stat_conflict_cnt_out(stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 4-stage multiplier.
   logic [21:0] mpipe [4];
   always @(posedge clk) begin
      mpipe[0] <= 22'(mul_gx) * 22'(mul_gy);
      for (int k = 1; k < 4; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_product = mpipe[3];

   typedef struct {
      logic [3:0]  vld;
      logic [21:0] prod;
      int          due;
   } exp_t;
   exp_t sb_q[$];

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input logic [3:0] vld, input logic [21:0] prod, input int due);
      exp_t e;
      e.vld = vld; e.prod = prod; e.due = due;
      sb_q.push_back(e);
   endtask

   task automatic set_ops(input int i, input logic [10:0] gx, input logic [10:0] gy,
                          input logic [4:0] ex, input logic [4:0] ey);
      req_gx[i*11 +: 11] = gx;
      req_gy[i*11 +: 11] = gy;
      req_ex[i*5 +: 5]   = ex;
      req_ey[i*5 +: 5]   = ey;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every response pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rsp_valid !== 4'b0000) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e.vld));
            check("rsp_product", 64'(rsp_product), 64'(e.prod));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   logic [21:0] prod_tab [4] = '{22'd6, 22'd9, 22'd12, 22'd15};
   int wrap_ord [3] = '{3, 1, 3};
   int t0;

   initial begin
      do_reset();
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_issue", 64'(mul_issue), 64'd0);
      check("rst_rsp", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_prod", 64'(rsp_product), 64'd0);

      // Single issue from requester 2.
      set_ops(2, 11'h400, 11'h400, 5'd3, 5'd4);
      req_valid = 4'b0100;
      #1;
      check("single_ready", 64'(req_ready), 64'h4);
      t0 = cyc;
      push(4'b0100, 22'h100000, t0 + 6);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         req_valid = 4'b0000;
         if (k == 1) begin
            check("single_issue", 64'(mul_issue), 64'd1);
            check("single_gx", 64'(mul_gx), 64'h400);
            check("single_gy", 64'(mul_gy), 64'h400);
            check("single_ex", 64'(mul_ex), 64'd3);
            check("single_ey", 64'(mul_ey), 64'd4);
         end
         if (k == 2) begin
            check("single_noissue", 64'(mul_issue), 64'd0);
            check("single_hold_gx", 64'(mul_gx), 64'h400);
         end
         check("single_busy", 64'(busy), (k <= 6) ? 64'd1 : 64'd0);
      end

      // Fairness: all four valid for 8 cycles from a fresh pointer.
      do_reset();
      for (int i = 0; i < 4; i++) set_ops(i, 11'(i + 2), 11'd3, 5'(i), 5'(i + 1));
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         req_valid = 4'hF;
         #1;
         check("fair_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         push(4'b0001 << (k % 4), prod_tab[k % 4], cyc + 6);
         if (k > 0) begin
            check("fair_issue", 64'(mul_issue), 64'd1);
            check("fair_gx", 64'(mul_gx), 64'((k - 1) % 4 + 2));
         end
      end
      @(negedge clk);
      req_valid = 4'b0000;
      check("fair_issue_last", 64'(mul_issue), 64'd1);
      check("fair_gx_last", 64'(mul_gx), 64'd5);
`ifdef FMUL_ARB_STATS_EN
      for (int i = 0; i < 4; i++) check("stat_grant", 64'(stat_grant[i*16 +: 16]), 64'd2);
      check("stat_conflict", 64'(stat_conflict), 64'd8);
`endif
      repeat (10) @(negedge clk);

      // Wrap and skip: move pointer to 3, then only requesters 1 and 3 valid.
      req_valid = 4'b0100;
      #1;
      check("wrap_pre", 64'(req_ready), 64'h4);
      push(4'b0100, 22'd12, cyc + 6);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = 4'b1010;
         #1;
         check("wrap_ready", 64'(req_ready), 64'(4'b0001 << wrap_ord[k]));
         push(4'b0001 << wrap_ord[k], prod_tab[wrap_ord[k]], cyc + 6);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (10) @(negedge clk);

      // Flush: three back-to-back issues, flush two cycles after the last grant.
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         req_valid = 4'b0111;
         #1;
         check("flush_grant", 64'(req_ready), 64'(4'b0001 << k));
      end
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      flush = 1'b1;
      req_valid = 4'b0001;
      #1;
      check("flush_no_grant", 64'(req_ready), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      req_valid = 4'b0000;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_issue", 64'(mul_issue), 64'd0);
      repeat (8) @(negedge clk);
      req_valid = 4'b1000;
      #1;
      check("post_flush_ready", 64'(req_ready), 64'h8);
      push(4'b1000, 22'd15, cyc + 6);
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (8) @(negedge clk);

      // Reset mid-flight with two ops in the tag pipe.
      req_valid = 4'b0011;
      @(negedge clk);
      @(negedge clk);
      req_valid = 4'b0000;
      @(posedge clk);
      #2;
      rst = 1'b1;
      req_valid = 4'b0001;
      #1;
      check("arst_ready", 64'(req_ready), 64'd0);
      check("arst_issue", 64'(mul_issue), 64'd0);
      check("arst_gx", 64'(mul_gx), 64'd0);
      check("arst_ex", 64'(mul_ex), 64'd0);
      check("arst_rsp", 64'(rsp_valid), 64'd0);
      check("arst_prod", 64'(rsp_product), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      req_valid = 4'b0000;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("arst_busy_after", 64'(busy), 64'd0);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
